// File: rtl/game_pkg.sv
// Shared definitions for the score/fever game blocks: FSM state encoding
// and the digit constants understood by the seven-segment decoder.
package game_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    FEVER  = 1'b1
  } state_e;

  localparam logic [3:0] FEVER_DIGIT = 4'd10;  // decoder renders this as "F"
  localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage : game_pkg

// File: rtl/bcd_sat_adder.sv
// Two-digit BCD adder for small increments (1 or 2) with the result
// clamped at 99 instead of wrapping.
module bcd_sat_adder
  import game_pkg::*;
(
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [1:0] inc,
  output logic [3:0] sum_tens,
  output logic [3:0] sum_ones
);

  logic [4:0] ones_sum;
  logic [4:0] ones_wrap;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ones_sum  = {1'b0, ones} + {3'b000, inc};
    ones_wrap = ones_sum - 5'd10;
    sum_tens  = tens;
    sum_ones  = ones_sum[3:0];
    if (ones_sum > {1'b0, BCD_MAX}) begin
      if (tens == BCD_MAX) begin
        // A carry out of 9x can only overshoot 99, so clamp both digits.
        sum_tens = BCD_MAX;
        sum_ones = BCD_MAX;
      end else begin
        sum_tens = tens + 4'd1;
        sum_ones = ones_wrap[3:0];
      end
    end
  end

endmodule : bcd_sat_adder

// File: rtl/fever_score_counter.sv
// Hit/miss score keeper: a run of COMBO_TARGET hits starts a timed fever
// mode in which each hit is worth 2 and the tens display shows "F".
module fever_score_counter
  import game_pkg::*;
#(
  parameter int COMBO_TARGET = 5,
  parameter int FEVER_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit,
  input  logic       miss,
  input  logic       clear,
  output logic [3:0] ones_digit,
  output logic [3:0] tens_digit,
  output logic       fever_active
);

  localparam int             TW         = $clog2(FEVER_CYCLES + 1);
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(FEVER_CYCLES - 1);
  localparam logic [3:0]     COMBO_MAX  = 4'(COMBO_TARGET);

  state_e          state_q, state_d;
  logic [3:0]      combo_q, combo_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [3:0]      disp_tens_q, disp_tens_d;
  logic [1:0]      inc;
  logic [3:0]      sum_tens, sum_ones;

  assign inc = (state_q == FEVER) ? 2'd2 : 2'd1;

  bcd_sat_adder u_adder (
    .tens     (tens_q),
    .ones     (ones_q),
    .inc      (inc),
    .sum_tens (sum_tens),
    .sum_ones (sum_ones)
  );

  always_comb begin
    state_d = state_q;
    combo_d = combo_q;
    timer_d = timer_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (clear) begin
      state_d = NORMAL;
      combo_d = '0;
      timer_d = '0;
      tens_d  = '0;
      ones_d  = '0;
    end else if (miss) begin
      // Miss wins over a simultaneous hit: the hit is dropped entirely.
      state_d = NORMAL;
      combo_d = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        NORMAL: begin
          if (hit) begin
            tens_d = sum_tens;
            ones_d = sum_ones;
            if (combo_q + 4'd1 >= COMBO_MAX) begin
              state_d = FEVER;
              timer_d = TIMER_LOAD;
              combo_d = '0;
            end else begin
              combo_d = combo_q + 4'd1;
            end
          end
        end
        FEVER: begin
          if (hit) begin
            tens_d = sum_tens;
            ones_d = sum_ones;
          end
          // Timer counts the remaining fever cycles after this one.
          if (timer_q == '0) begin
            state_d = NORMAL;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: state_d = NORMAL;
      endcase
    end
    disp_tens_d = (state_d == FEVER) ? FEVER_DIGIT : tens_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, and the asynchronous reset clears every flop regardless of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      combo_q     <= '0;
      timer_q     <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      disp_tens_q <= '0;
    end else begin
      state_q     <= state_d;
      combo_q     <= combo_d;
      timer_q     <= timer_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      disp_tens_q <= disp_tens_d;
    end
  end

  assign ones_digit   = ones_q;
  assign tens_digit   = disp_tens_q;
  assign fever_active = (state_q == FEVER);

endmodule : fever_score_counter
